seq_detector_param: RTL
=======================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_LEN, default 3: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 3'b101: target sequence, PAT_LEN bits wide; MSB is the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  in_bit is consumed on this cycle.
REQ-008 SHALL have port in_bit  input  1  serial data bit.
REQ-009 SHALL have port clear  input  1  synchronous flush of history and counter.
REQ-010 SHALL have port detected  output  1  Mealy match flag, combinational in the same cycle as the final bit.
REQ-011 SHALL have port detected_q  output  1  registered copy of detected, one cycle later.
REQ-012 SHALL have port match_count  output  CNT_W  saturating count of matches.

Function
REQ-013 SHALL hold hist, a PAT_LEN-1 bit history of accepted bits, and fill, a counter of accepted bits that saturates at PAT_LEN-1.
REQ-014 SHALL accept a bit only when in_valid=1; when in_valid=0, hist, fill and match_count hold and detected=0.
REQ-015 SHALL drive detected=1 when all of these hold: in_valid=1, clear=0, fill==PAT_LEN-1, and {hist,in_bit}==PATTERN.
REQ-016 SHALL update on an accepted bit as follows: hist <= {hist[PAT_LEN-3:0],in_bit}, or hist <= in_bit when PAT_LEN=2; fill <= min(fill+1, PAT_LEN-1).
REQ-017 SHALL behave on a match with OVERLAP=1 by leaving fill at PAT_LEN-1, so the match suffix can start the next match.
REQ-018 SHALL behave on a match with OVERLAP=0 by setting fill <= 0, so no bit of a matched sequence is reused.
REQ-019 SHALL increment match_count by 1 on each cycle where detected=1, and hold it at 2^CNT_W-1 once saturated.
REQ-020 SHALL give clear=1 priority over in_valid: fill <= 0, hist <= 0, match_count <= 0, detected=0, detected_q <= 0.
REQ-021 SHALL register detected_q <= detected every cycle, so its latency is exactly 1 clk.
REQ-022 SHALL produce identical behaviour to a fixed-pattern overlapping Mealy 101 detector under default parameters with in_valid tied to 1.
REQ-023 SHALL fail elaboration (generate-time error) when PAT_LEN<2 or PAT_LEN>16.

Reset
REQ-024 SHALL, on reset=1, asynchronously set hist=0, fill=0, match_count=0 and detected_q=0.
REQ-025 SHALL force detected=0 while reset=1.
REQ-026 SHALL, on reset asserted mid-sequence, discard all partial history; detection requires PAT_LEN new accepted bits after release.

Structure
REQ-027 SHALL take default parameter values and the OVERLAP mode encodings from shared package seq_det_pkg.
REQ-028 SHALL place the saturating counter in sub-module sat_counter (params WIDTH; ports clk, reset, clr, inc, count).
REQ-029 SHALL keep the history register, fill counter and compare in the top module as a single sequential block plus a single combinational block.

Verification
REQ-030 Defaults, in_valid=1, bits 1,0,1,0,1 -> detected high on bits 3 and 5; match_count=2; detected_q high one cycle after each.
REQ-031 OVERLAP=0, bits 1,0,1,0,1,0,1 -> detected high on bits 3 and 7 only; match_count=2.
REQ-032 Defaults, bits 1,(in_valid=0 for 3 cycles),0,1 -> detected high on the third accepted bit only; no pulse during gap cycles.
REQ-033 PAT_LEN=4, PATTERN=4'b1101, OVERLAP=1, bits 1,1,0,1,1,0,1 -> detected on bits 4 and 7; match_count=2.
REQ-034 Defaults, bits 1,0, then clear=1 with in_bit=1, then bit 1 -> no detection; match_count=0; next 0,1 -> detected high.
REQ-035 CNT_W=2, five matches of 101 -> match_count sequence 1,2,3,3,3; async reset asserted mid-frame -> all state 0 immediately.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and overlap-mode encodings for the sequence detector
package seq_det_pkg;
    localparam int OVERLAP_OFF = 0;
    localparam int OVERLAP_ON = 1;
    localparam int DEF_PAT_LEN = 3;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 3'b101;
    localparam int DEF_OVERLAP = OVERLAP_ON;
    localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            count <= '0;
        else
            count <= clr ? '0 : (inc && count != '1) ? count + 1'b1 : count;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: Mealy detector for a PAT_LEN-bit serial pattern, with
// optional overlap, gapped input (in_valid), flush and a saturating match count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter int OVERLAP = DEF_OVERLAP,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             detected,
    output logic             detected_q,
    output logic [CNT_W-1:0] match_count
);
    localparam int FW = $clog2(PAT_LEN);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);

    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
        $error("seq_detector_param: PAT_LEN must be in 2..16");
    end

    logic [PAT_LEN-2:0] hist, hist_n;
    logic [FW-1:0]      fill, fill_n;
    logic [PAT_LEN-1:0] sh;
    logic               full;

    // Shifting through a PAT_LEN-wide window keeps PAT_LEN=2 free of a negative slice
    always_comb begin
        sh = {hist, in_bit};
        full = fill == FULL;
        detected = !reset && in_valid && !clear && full && sh == PATTERN;
        hist_n = clear ? '0 : in_valid ? sh[PAT_LEN-2:0] : hist;
        fill_n = clear ? '0 : !in_valid ? fill :
                 (detected && OVERLAP == OVERLAP_OFF) ? '0 : full ? fill : fill + 1'b1;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            hist <= '0;
            fill <= '0;
            detected_q <= 1'b0;
        end else begin
            hist <= hist_n;
            fill <= fill_n;
            detected_q <= detected;
        end

    sat_counter #(.WIDTH(CNT_W)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clear),
        .inc  (detected),
        .count(match_count)
    );
endmodule
